mac_ram_loader: RTL and testbench

Write-side front end for the dual-RAM multiply-accumulate datapath. It accepts a stream of operand pairs over a valid/ready handshake and writes them into the two operand RAMs at consecutive addresses 0..DEPTH-1. After the last write commits, it pulses `start` to the MAC sequencer, then holds off further loads until the sequencer reports `mac_done`. The MAC sequencer only reads and sweeps the RAMs; this block is the writer for that reader.

---
 rtl/mac_ram_loader.sv | 112 +++++++++++
 tb/tb_mac_ram_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ram_loader.sv
// Write-side loader for the dual operand RAMs: streams DEPTH operand pairs into
// addresses 0..DEPTH-1, kicks the MAC sequencer, then waits for it to finish.
module mac_ram_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data1,
  output logic [DW-1:0] wr_data2,
  output logic          start,
  input  logic          mac_done,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_START,
    S_WAIT
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] count;
  logic [AW-1:0] count_nxt;
  logic          accept;

  // abort withdraws ready in the same cycle so no pair slips in during cancel
  assign in_ready = (state == S_LOAD) && !abort;
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (abort) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_req) begin
            state_nxt = S_LOAD;
            count_nxt = '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (count == LAST_ADDR) begin
              state_nxt = S_COMMIT;
              count_nxt = '0;
            end else begin
              count_nxt = count + AW'(1);
            end
          end
        end
        S_COMMIT: state_nxt = S_START;
        S_START:  state_nxt = S_WAIT;
        S_WAIT: begin
          if (mac_done) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // write port and start strobe are registered; address/data hold between writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data1 <= '0;
      wr_data2 <= '0;
      start    <= 1'b0;
    end else begin
      wr_en <= accept;
      start <= (state == S_COMMIT) && !abort;
      if (accept) begin
        wr_addr  <= count;
        wr_data1 <= in_data1;
        wr_data2 <= in_data2;
      end
    end
  end

endmodule

// File: tb/tb_mac_ram_loader.sv
// Bench for mac_ram_loader: a DEPTH=16 and a DEPTH=4 instance share one stimulus
// stream and are each compared every cycle against a transaction-level model.
module tb_mac_ram_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req, abort, in_valid, mac_done;
  logic [7:0] in_data1, in_data2;

  logic       rdy16, wen16, st16, busy16;
  logic [3:0] addr16;
  logic [7:0] d1_16, d2_16;
  logic       rdy4, wen4, st4, busy4;
  logic [1:0] addr4;
  logic [7:0] d1_4, d2_4;

  int nchecks = 0;
  int nerr    = 0;
  int wen16_count = 0;

  always #5 clk = ~clk;

  mac_ram_loader #(.DEPTH(16), .AW(4), .DW(8)) dut16 (
    .clk(clk), .reset(reset), .load_req(load_req), .abort(abort),
    .in_valid(in_valid), .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(rdy16), .wr_en(wen16), .wr_addr(addr16), .wr_data1(d1_16),
    .wr_data2(d2_16), .start(st16), .mac_done(mac_done), .busy(busy16)
  );

  mac_ram_loader #(.DEPTH(4), .AW(2), .DW(8)) dut4 (
    .clk(clk), .reset(reset), .load_req(load_req), .abort(abort),
    .in_valid(in_valid), .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(rdy4), .wr_en(wen4), .wr_addr(addr4), .wr_data1(d1_4),
    .wr_data2(d2_4), .start(st4), .mac_done(mac_done), .busy(busy4)
  );

  // Reference model: phase of the load transaction plus the last committed write.
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2, P_START = 3, P_WAIT = 4;
  typedef struct {
    int ph;
    int cnt;
    bit wen;
    int addr;
    int d1;
    int d2;
    bit st;
  } mdl_t;

  mdl_t m16, m4;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.ph = P_IDLE; r.cnt = 0; r.wen = 0; r.addr = 0; r.d1 = 0; r.d2 = 0; r.st = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int depth, bit lr, bit ab, bit iv,
                                    bit md, int a, int b);
    mdl_t n;
    bit acc;
    n   = m;
    acc = (m.ph == P_LOAD) && !ab && iv;
    n.wen = acc;
    n.st  = (m.ph == P_COMMIT) && !ab;
    if (acc) begin
      n.addr = m.cnt; n.d1 = a; n.d2 = b;
    end
    if (ab) begin
      n.ph = P_IDLE; n.cnt = 0;
    end else if (m.ph == P_IDLE && lr) begin
      n.ph = P_LOAD; n.cnt = 0;
    end else if (acc) begin
      if (m.cnt + 1 == depth) begin
        n.ph = P_COMMIT; n.cnt = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else if (m.ph == P_COMMIT) n.ph = P_START;
    else if (m.ph == P_START) n.ph = P_WAIT;
    else if (m.ph == P_WAIT && md) n.ph = P_IDLE;
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(string tag, mdl_t m, bit ab, logic rdy, logic bsy,
                           logic wen, int addr, int d1, int d2, logic st);
    chk({tag, ".in_ready"}, int'(rdy), int'(m.ph == P_LOAD && !ab));
    chk({tag, ".busy"},     int'(bsy), int'(m.ph != P_IDLE));
    chk({tag, ".wr_en"},    int'(wen), int'(m.wen));
    chk({tag, ".start"},    int'(st),  int'(m.st));
    chk({tag, ".wr_addr"},  addr, m.addr);
    chk({tag, ".wr_data1"}, d1, m.d1);
    chk({tag, ".wr_data2"}, d2, m.d2);
  endtask

  task automatic check_zero(string tag, logic rdy, logic bsy, logic wen, int addr,
                            int d1, int d2, logic st);
    chk({tag, ".rst_in_ready"}, int'(rdy), 0);
    chk({tag, ".rst_busy"},     int'(bsy), 0);
    chk({tag, ".rst_wr_en"},    int'(wen), 0);
    chk({tag, ".rst_start"},    int'(st),  0);
    chk({tag, ".rst_wr_addr"},  addr, 0);
    chk({tag, ".rst_wr_data"},  d1 + d2, 0);
  endtask

  // Called at posedge+1: asserts reset asynchronously and checks outputs before any edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("d16", rdy16, busy16, wen16, int'(addr16), int'(d1_16), int'(d2_16), st16);
    check_zero("d4",  rdy4,  busy4,  wen4,  int'(addr4),  int'(d1_4),  int'(d2_4),  st4);
    m16 = mdl_reset();
    m4  = mdl_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic apply(bit lr, bit ab, bit iv, bit md, int a, int b);
    load_req = lr; abort = ab; in_valid = iv; mac_done = md;
    in_data1 = a[7:0]; in_data2 = b[7:0];
    @(negedge clk);
    check_dut("d16", m16, ab, rdy16, busy16, wen16, int'(addr16), int'(d1_16), int'(d2_16), st16);
    check_dut("d4",  m4,  ab, rdy4,  busy4,  wen4,  int'(addr4),  int'(d1_4),  int'(d2_4),  st4);
  endtask

  task automatic advance();
    mdl_t n16, n4;
    n16 = mdl_next(m16, 16, load_req, abort, in_valid, mac_done, int'(in_data1), int'(in_data2));
    n4  = mdl_next(m4,  4,  load_req, abort, in_valid, mac_done, int'(in_data1), int'(in_data2));
    @(posedge clk); #1;
    if (wen16) wen16_count++;
    m16 = n16;
    m4  = n4;
  endtask

  task automatic step(bit lr, bit ab, bit iv, bit md, int a, int b);
    apply(lr, ab, iv, md, a, b);
    advance();
  endtask

  typedef struct {
    bit lr, ab, iv, md;
    int a, b;
    bit e_rdy, e_busy, e_wen, e_st;
    int e_addr, e_d1;
  } vec_t;

  vec_t vt[12];

  initial begin
    reset = 1'b0; load_req = 0; abort = 0; in_valid = 0; mac_done = 0;
    in_data1 = 0; in_data2 = 0;
    m16 = mdl_reset(); m4 = mdl_reset();

    // Hand-derived vectors for the DEPTH=4 instance, expected outputs within each cycle.
    vt[0]  = '{1,0,0,0,  0,  0, 0,0,0,0, 0,  0};
    vt[1]  = '{0,0,1,0, 10, 20, 1,1,0,0, 0,  0};
    vt[2]  = '{0,0,1,0, 11, 21, 1,1,1,0, 0, 10};
    vt[3]  = '{0,0,1,0, 12, 22, 1,1,1,0, 1, 11};
    vt[4]  = '{0,0,1,0, 13, 23, 1,1,1,0, 2, 12};
    vt[5]  = '{0,0,1,0, 99, 99, 0,1,1,0, 3, 13};
    vt[6]  = '{0,0,0,0,  0,  0, 0,1,0,1, 3, 13};
    vt[7]  = '{1,0,1,0, 50, 50, 0,1,0,0, 3, 13};
    vt[8]  = '{0,0,0,1,  0,  0, 0,1,0,0, 3, 13};
    vt[9]  = '{0,0,0,1,  0,  0, 0,0,0,0, 3, 13};
    vt[10] = '{1,1,0,0,  0,  0, 0,0,0,0, 3, 13};
    vt[11] = '{0,0,1,0,  0,  0, 0,0,0,0, 3, 13};

    #2;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      apply(vt[i].lr, vt[i].ab, vt[i].iv, vt[i].md, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d.in_ready", i), int'(rdy4),  int'(vt[i].e_rdy));
      chk($sformatf("vec%0d.busy", i),     int'(busy4), int'(vt[i].e_busy));
      chk($sformatf("vec%0d.wr_en", i),    int'(wen4),  int'(vt[i].e_wen));
      chk($sformatf("vec%0d.start", i),    int'(st4),   int'(vt[i].e_st));
      chk($sformatf("vec%0d.wr_addr", i),  int'(addr4), vt[i].e_addr);
      chk($sformatf("vec%0d.wr_data1", i), int'(d1_4),  vt[i].e_d1);
      advance();
    end

    // Full load, in_valid held high.
    do_reset();
    wen16_count = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, i, 8'hF0 + i);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("full_load.write_count", wen16_count, 16);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // in_valid toggling every other cycle.
    wen16_count = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, (i % 2) == 0, 0, i / 2, 8'hF0 + i / 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("toggle_load.write_count", wen16_count, 16);
    step(0, 0, 0, 1, 0, 0);

    // Abort after five accepts, then reload from address 0.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 40 + i, 80 + i);
    step(0, 1, 1, 0, 45, 85);
    step(0, 0, 1, 0, 46, 86);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 60 + i, 70 + i);
    step(0, 0, 0, 0, 0, 0);

    // WAIT ignores load_req/in_valid; mac_done releases; mac_done in IDLE does nothing.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 3 * i, 255 - i);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 7, 7);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // Asynchronous reset while wr_addr shows 9, then a fresh load restarts at 0.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 100 + i, 200 + i);
    chk("pre_reset.wr_addr", int'(addr16), 9);
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 20 + i, 30 + i);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 50) == 0, ($urandom % 3) != 0,
           ($urandom % 8) == 0, int'($urandom % 256), int'($urandom % 256));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
